// File: rtl/tx_rx_sequencer_if.sv
// ---------------------------------------------------------------------------
// tx_rx_sequencer_if
// Groups the control/handshake signals of the TX/RX sequencer.
//   start       : request to begin one transfer          (master -> slave)
//   abort       : request to end the current transfer    (master -> slave)
//   rx_valid    : receiver word-valid, one word per cycle (master -> slave)
//   ctr_clr     : transmitter counter clear               (slave -> master)
//   ctr_en      : transmitter counter enable              (slave -> master)
//   conv_en_n   : active-low converter enable             (slave -> master)
//   busy        : high in every state except IDLE         (slave -> master)
//   done        : one-cycle completion pulse              (slave -> master)
//   timeout_err : sticky timeout flag                     (slave -> master)
//   word_cnt    : words received in current/last transfer (slave -> master)
// ---------------------------------------------------------------------------
interface tx_rx_sequencer_if;
    logic        start;
    logic        abort;
    logic        rx_valid;
    logic        ctr_clr;
    logic        ctr_en;
    logic        conv_en_n;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [15:0] word_cnt;

    modport master (
        output start, abort, rx_valid,
        input  ctr_clr, ctr_en, conv_en_n, busy, done, timeout_err, word_cnt
    );

    modport slave (
        input  start, abort, rx_valid,
        output ctr_clr, ctr_en, conv_en_n, busy, done, timeout_err, word_cnt
    );
endinterface

// File: rtl/tx_rx_sequencer.sv
// ---------------------------------------------------------------------------
// tx_rx_sequencer
// Sequences one transmit/receive transfer: clear the transmitter counter,
// wait, start counting, let it settle, then enable the converters and count
// receiver words until NUM_WORDS arrive or the receiver goes silent for
// TIMEOUT cycles.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : control bus (slave side), see tx_rx_sequencer_if
// All outputs are registered and decoded from the next state so they move
// on the same edge as the state they belong to.
// ---------------------------------------------------------------------------
module tx_rx_sequencer #(
    parameter int CLR_CYC    = 4,
    parameter int ARM_CYC    = 5,
    parameter int SETTLE_CYC = 5,
    parameter int NUM_WORDS  = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    tx_rx_sequencer_if.slave   bus
);

    // Phase counter sized for the longest fixed phase.
    localparam int MAX_PH = (CLR_CYC > ARM_CYC) ?
                            ((CLR_CYC > SETTLE_CYC) ? CLR_CYC : SETTLE_CYC) :
                            ((ARM_CYC > SETTLE_CYC) ? ARM_CYC : SETTLE_CYC);
    localparam int PH_W   = (MAX_PH > 1) ? $clog2(MAX_PH + 1) : 1;
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_HOLD  = 3'd2,
        S_COUNT = 3'd3,
        S_RUN   = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t            r_state_reg, w_state_next;
    logic [PH_W-1:0]   r_ph_reg, w_ph_next;
    logic [TO_W-1:0]   r_idle_reg, w_idle_next;
    logic [15:0]       r_word_cnt_reg, w_word_cnt_next;
    logic              r_terr_reg, w_terr_next;

    logic              r_ctr_clr_reg;
    logic              r_ctr_en_reg;
    logic              r_conv_en_n_reg;
    logic              r_busy_reg;
    logic              r_done_reg;

    logic [15:0]       w_word_inc;
    assign w_word_inc = r_word_cnt_reg + 16'd1;

    // -----------------------------------------------------------------------
    // Next-state and counter logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state_reg;
        w_ph_next       = r_ph_reg;
        w_idle_next     = r_idle_reg;
        w_word_cnt_next = r_word_cnt_reg;
        w_terr_next     = r_terr_reg;

        // Abort beats everything outside IDLE; word_cnt deliberately held.
        if ((r_state_reg != S_IDLE) && bus.abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        w_state_next    = S_CLEAR;
                        w_ph_next       = '0;
                        w_word_cnt_next = '0;
                        w_terr_next     = 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (r_ph_reg == PH_W'(CLR_CYC - 1)) begin
                        w_state_next = S_HOLD;
                        w_ph_next    = '0;
                    end else begin
                        w_ph_next = r_ph_reg + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_ph_reg == PH_W'(ARM_CYC - 1)) begin
                        w_state_next = S_COUNT;
                        w_ph_next    = '0;
                    end else begin
                        w_ph_next = r_ph_reg + 1'b1;
                    end
                end
                S_COUNT: begin
                    if (r_ph_reg == PH_W'(SETTLE_CYC - 1)) begin
                        w_state_next = S_RUN;
                        w_ph_next    = '0;
                        w_idle_next  = '0;
                    end else begin
                        w_ph_next = r_ph_reg + 1'b1;
                    end
                end
                S_RUN: begin
                    // A word in the same cycle as expiry counts as activity.
                    if (bus.rx_valid) begin
                        w_word_cnt_next = w_word_inc;
                        w_idle_next     = '0;
                        if (w_word_inc == 16'(NUM_WORDS)) begin
                            w_state_next = S_DONE;
                        end
                    end else if (r_idle_reg == TO_W'(TIMEOUT - 1)) begin
                        w_state_next = S_ERR;
                        w_terr_next  = 1'b1;
                    end else begin
                        w_idle_next = r_idle_reg + 1'b1;
                    end
                end
                S_DONE:  w_state_next = S_IDLE;
                S_ERR:   w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State, counters and registered output decode
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_reg     <= S_IDLE;
            r_ph_reg        <= '0;
            r_idle_reg      <= '0;
            r_word_cnt_reg  <= '0;
            r_terr_reg      <= 1'b0;
            r_ctr_clr_reg   <= 1'b0;
            r_ctr_en_reg    <= 1'b0;
            r_conv_en_n_reg <= 1'b1;
            r_busy_reg      <= 1'b0;
            r_done_reg      <= 1'b0;
        end else begin
            r_state_reg     <= w_state_next;
            r_ph_reg        <= w_ph_next;
            r_idle_reg      <= w_idle_next;
            r_word_cnt_reg  <= w_word_cnt_next;
            r_terr_reg      <= w_terr_next;
            r_ctr_clr_reg   <= (w_state_next == S_CLEAR);
            r_ctr_en_reg    <= (w_state_next == S_COUNT) || (w_state_next == S_RUN);
            r_conv_en_n_reg <= (w_state_next != S_RUN);
            r_busy_reg      <= (w_state_next != S_IDLE);
            r_done_reg      <= (w_state_next == S_DONE);
        end
    end

    assign bus.ctr_clr     = r_ctr_clr_reg;
    assign bus.ctr_en      = r_ctr_en_reg;
    assign bus.conv_en_n   = r_conv_en_n_reg;
    assign bus.busy        = r_busy_reg;
    assign bus.done        = r_done_reg;
    assign bus.timeout_err = r_terr_reg;
    assign bus.word_cnt    = r_word_cnt_reg;

endmodule

// File: tb/tb_tx_rx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tx_rx_sequencer
// Scenario-driven bench. Expected outputs come from elapsed-cycle arithmetic
// (edge t after an accepted start) and a running word count model.
// ---------------------------------------------------------------------------
module tb_tx_rx_sequencer;

    localparam int CLR   = 4;
    localparam int ARM   = 5;
    localparam int SET   = 5;
    localparam int NW    = 16;
    localparam int TO    = 64;
    localparam int RUN_T = CLR + ARM + SET + 1;   // edge (from start edge 1) where RUN begins

    logic clk;
    logic rst_n;

    tx_rx_sequencer_if bus();

    tx_rx_sequencer #(
        .CLR_CYC(CLR), .ARM_CYC(ARM), .SETTLE_CYC(SET),
        .NUM_WORDS(NW), .TIMEOUT(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int m_cnt  = 0;   // model of words received in the current transfer

    // Drive inputs for one cycle, then sample 1 time unit after the edge.
    task automatic tick(input logic s, input logic a, input logic v);
        bus.start    = s;
        bus.abort    = a;
        bus.rx_valid = v;
        @(posedge clk);
        #1;
    endtask

    // Start a transfer and advance to the edge where RUN is entered.
    task automatic launch();
        tick(1'b1, 1'b0, 1'b0);
        repeat (RUN_T - 1) tick(1'b0, 1'b0, 1'b0);
        m_cnt = 0;
    endtask

    // Deliver n words in RUN with random silent gaps, tracking the model count.
    task automatic run_words(input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, maxgap);
            for (int g = 0; g < gap; g++) begin
                tick(1'b0, 1'b0, 1'b0);
                checks++;
                if ({bus.busy, bus.word_cnt} !== {1'b1, 16'(m_cnt)})
                    $display("FAIL gap_wait busy/word_cnt=%b/%0d exp 1/%0d", bus.busy, bus.word_cnt, m_cnt);
                else passes++;
            end
            tick(1'b0, 1'b0, 1'b1);
            m_cnt++;
            checks++;
            if (m_cnt == NW) begin
                if ({bus.word_cnt, bus.ctr_en, bus.conv_en_n, bus.done, bus.busy} !== {16'(NW), 4'b0111})
                    $display("FAIL word_done cnt=%0d en=%b conv_n=%b done=%b busy=%b exp %0d/0/1/1/1",
                             bus.word_cnt, bus.ctr_en, bus.conv_en_n, bus.done, bus.busy, NW);
                else passes++;
            end else begin
                if ({bus.word_cnt, bus.ctr_en, bus.conv_en_n, bus.done, bus.busy} !== {16'(m_cnt), 4'b1001})
                    $display("FAIL word_run cnt=%0d en=%b conv_n=%b done=%b busy=%b exp %0d/1/0/0/1",
                             bus.word_cnt, bus.ctr_en, bus.conv_en_n, bus.done, bus.busy, m_cnt);
                else passes++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick(1'b1, 1'b0, 1'b1);
        checks++;
        if ({bus.ctr_clr, bus.ctr_en, bus.conv_en_n, bus.busy, bus.done, bus.timeout_err, bus.word_cnt} !== {6'b001000, 16'd0})
            $display("FAIL reset clr/en/conv_n/busy/done/terr=%b%b%b%b%b%b cnt=%0d exp 001000 0",
                     bus.ctr_clr, bus.ctr_en, bus.conv_en_n, bus.busy, bus.done, bus.timeout_err, bus.word_cnt);
        else passes++;
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_idle busy=%b exp 0", bus.busy);
        else passes++;
        $display("test_reset done");
    endtask

    // Phase timing from edge arithmetic, optionally with start/rx_valid noise.
    task automatic phase_walk(input bit noisy, input string tag);
        tick(1'b1, 1'b0, 1'b0);
        for (int t = 1; t <= RUN_T; t++) begin
            logic [4:0] exp;
            if (t > 1) begin
                if (noisy) tick(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
                else       tick(1'b0, 1'b0, 1'b0);
            end
            exp = {1'(t <= CLR), 1'(t > CLR + ARM), 1'(!(t > CLR + ARM + SET)), 1'b1, 1'b0};
            checks++;
            if ({bus.ctr_clr, bus.ctr_en, bus.conv_en_n, bus.busy, bus.done, bus.word_cnt} !== {exp, 16'd0})
                $display("FAIL %s edge=%0d clr/en/conv_n/busy/done=%b%b%b%b%b cnt=%0d exp %b 0", tag, t,
                         bus.ctr_clr, bus.ctr_en, bus.conv_en_n, bus.busy, bus.done, bus.word_cnt, exp);
            else passes++;
        end
        m_cnt = 0;
    endtask

    task automatic test_nominal();
        for (int k = 0; k < 3; k++) begin
            phase_walk(1'b0, "nominal_phase");
            run_words(NW, (k == 0) ? 0 : 6);
            tick(1'b0, 1'b0, 1'b0);
            checks++;
            if ({bus.busy, bus.done, bus.word_cnt} !== {2'b00, 16'(NW)})
                $display("FAIL nominal_after busy/done=%b%b cnt=%0d exp 00 %0d", bus.busy, bus.done, bus.word_cnt, NW);
            else passes++;
            $display("transfer nominal #%0d words=%0d", k, m_cnt);
        end
    endtask

    task automatic test_start_busy();
        phase_walk(1'b1, "busy_phase");
        run_words(NW, 3);
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL busy_end busy=%b exp 0", bus.busy);
        else passes++;
        // start together with abort while in CLEAR
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        checks++;
        if ({bus.busy, bus.ctr_clr, bus.ctr_en, bus.conv_en_n, bus.done} !== 5'b00010)
            $display("FAIL start_abort busy/clr/en/conv_n/done=%b%b%b%b%b exp 00010",
                     bus.busy, bus.ctr_clr, bus.ctr_en, bus.conv_en_n, bus.done);
        else passes++;
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL start_abort_idle busy=%b exp 0", bus.busy);
        else passes++;
        $display("transfer start_while_busy words=%0d", m_cnt);
    endtask

    task automatic test_back_to_back();
        launch();
        run_words(NW - 1, 2);
        tick(1'b1, 1'b0, 1'b1);
        checks++;
        if ({bus.done, bus.busy, bus.word_cnt} !== {2'b11, 16'(NW)})
            $display("FAIL b2b_done done/busy=%b%b cnt=%0d exp 11 %0d", bus.done, bus.busy, bus.word_cnt, NW);
        else passes++;
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.done, bus.busy} !== 2'b00) $display("FAIL b2b_idle done/busy=%b%b exp 00", bus.done, bus.busy);
        else passes++;
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.ctr_clr, bus.busy, bus.word_cnt} !== {2'b11, 16'd0})
            $display("FAIL b2b_restart clr/busy=%b%b cnt=%0d exp 11 0", bus.ctr_clr, bus.busy, bus.word_cnt);
        else passes++;
        tick(1'b0, 1'b1, 1'b0);
        $display("transfer back_to_back words=%0d", NW);
    endtask

    task automatic test_timeout();
        launch();
        run_words(3, 5);
        for (int i = 0; i < TO - 1; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            checks++;
            if ({bus.busy, bus.timeout_err} !== 2'b10)
                $display("FAIL to_wait idle=%0d busy/terr=%b%b exp 10", i + 1, bus.busy, bus.timeout_err);
            else passes++;
        end
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.busy, bus.timeout_err, bus.ctr_en, bus.conv_en_n, bus.done} !== 5'b11010)
            $display("FAIL to_err busy/terr/en/conv_n/done=%b%b%b%b%b exp 11010",
                     bus.busy, bus.timeout_err, bus.ctr_en, bus.conv_en_n, bus.done);
        else passes++;
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.busy, bus.timeout_err, bus.conv_en_n, bus.word_cnt} !== {3'b011, 16'd3})
            $display("FAIL to_idle busy/terr/conv_n=%b%b%b cnt=%0d exp 011 3",
                     bus.busy, bus.timeout_err, bus.conv_en_n, bus.word_cnt);
        else passes++;
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.timeout_err, bus.ctr_clr, bus.word_cnt} !== {2'b01, 16'd0})
            $display("FAIL to_clear terr/clr=%b%b cnt=%0d exp 01 0", bus.timeout_err, bus.ctr_clr, bus.word_cnt);
        else passes++;
        tick(1'b0, 1'b1, 1'b0);
        $display("transfer timeout words=3");
    endtask

    task automatic test_tie();
        launch();
        run_words(2, 3);
        repeat (TO - 1) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if ({bus.busy, bus.timeout_err, bus.conv_en_n, bus.word_cnt} !== {3'b100, 16'd3})
            $display("FAIL tie busy/terr/conv_n=%b%b%b cnt=%0d exp 100 3",
                     bus.busy, bus.timeout_err, bus.conv_en_n, bus.word_cnt);
        else passes++;
        repeat (TO - 1) tick(1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.busy, bus.timeout_err} !== 2'b10)
            $display("FAIL tie_reload busy/terr=%b%b exp 10", bus.busy, bus.timeout_err);
        else passes++;
        tick(1'b0, 1'b1, 1'b0);
        $display("transfer tie words=3");
    endtask

    task automatic test_abort();
        tick(1'b1, 1'b0, 1'b0);
        repeat (6) tick(1'b0, 1'b0, 1'b0);      // edge 7: in HOLD
        tick(1'b0, 1'b1, 1'b0);
        checks++;
        if ({bus.busy, bus.ctr_clr, bus.ctr_en, bus.conv_en_n, bus.done} !== 5'b00010)
            $display("FAIL abort_hold busy/clr/en/conv_n/done=%b%b%b%b%b exp 00010",
                     bus.busy, bus.ctr_clr, bus.ctr_en, bus.conv_en_n, bus.done);
        else passes++;
        launch();
        run_words(7, 3);
        tick(1'b0, 1'b1, 1'b0);
        checks++;
        if ({bus.busy, bus.ctr_clr, bus.ctr_en, bus.conv_en_n, bus.done, bus.word_cnt} !== {5'b00010, 16'd7})
            $display("FAIL abort_run busy/clr/en/conv_n/done=%b%b%b%b%b cnt=%0d exp 00010 7",
                     bus.busy, bus.ctr_clr, bus.ctr_en, bus.conv_en_n, bus.done, bus.word_cnt);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            checks++;
            if ({bus.done, bus.busy, bus.word_cnt} !== {2'b00, 16'd7})
                $display("FAIL abort_after done/busy=%b%b cnt=%0d exp 00 7", bus.done, bus.busy, bus.word_cnt);
            else passes++;
        end
        $display("transfer abort words=7");
    endtask

    task automatic test_reset_mid();
        launch();
        run_words(10, 2);
        rst_n = 1'b0;
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if ({bus.ctr_clr, bus.ctr_en, bus.conv_en_n, bus.busy, bus.done, bus.timeout_err, bus.word_cnt} !== {6'b001000, 16'd0})
            $display("FAIL reset_mid clr/en/conv_n/busy/done/terr=%b%b%b%b%b%b cnt=%0d exp 001000 0",
                     bus.ctr_clr, bus.ctr_en, bus.conv_en_n, bus.busy, bus.done, bus.timeout_err, bus.word_cnt);
        else passes++;
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) $display("FAIL reset_release busy/done=%b%b exp 00", bus.busy, bus.done);
        else passes++;
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.ctr_clr, bus.busy} !== 2'b11) $display("FAIL reset_restart clr/busy=%b%b exp 11", bus.ctr_clr, bus.busy);
        else passes++;
        tick(1'b0, 1'b1, 1'b0);
        $display("transfer reset_mid words=10");
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.rx_valid = 1'b0;
        rst_n        = 1'b0;
        test_reset();
        test_nominal();
        test_start_busy();
        test_back_to_back();
        test_timeout();
        test_tie();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tx_rx_sequencer.md
TX_RX_SEQUENCER -- requirements
Module: tx_rx_sequencer

Interface
REQ-001 Parameter CLR_CYC, default 4: cycles ctr_clr is held high.
REQ-002 Parameter ARM_CYC, default 5: idle cycles after clear, before counter enable.
REQ-003 Parameter SETTLE_CYC, default 5: cycles of counting before converters are enabled.
REQ-004 Parameter NUM_WORDS, default 16: receiver-valid words per transfer (range 1..65535).
REQ-005 Parameter TIMEOUT, default 64: maximum cycles in RUN without rx_valid (range 2..65535).
REQ-006 clk  input  1  single system clock, all logic on rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 start  input  1  request to begin one transfer.
REQ-009 abort  input  1  request to end the current transfer immediately.
REQ-010 rx_valid  input  1  receiver word-valid indication, one word per high cycle.
REQ-011 ctr_clr  output  1  transmitter counter clear.
REQ-012 ctr_en  output  1  transmitter counter enable.
REQ-013 conv_en_n  output  1  active-low converter enable (transmitter and receiver).
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse on successful completion.
REQ-016 timeout_err  output  1  sticky timeout flag.
REQ-017 word_cnt  output  16  words received in the current or last transfer.

Function
REQ-018 All outputs SHALL be registered and decoded from the next state, so each output changes on the same edge as the state it belongs to.
REQ-019 FSM states SHALL be IDLE, CLEAR, HOLD, COUNT, RUN, DONE and ERR.
REQ-020 IDLE: ctr_clr=0, ctr_en=0, conv_en_n=1; start=1 sampled -> CLEAR on the next edge, word_cnt cleared to 0, timeout_err cleared to 0.
REQ-021 CLEAR: ctr_clr=1 for exactly CLR_CYC cycles -> HOLD.
REQ-022 HOLD: ctr_clr=0, ctr_en=0 for exactly ARM_CYC cycles -> COUNT.
REQ-023 COUNT: ctr_en=1, conv_en_n=1 for exactly SETTLE_CYC cycles -> RUN.
REQ-024 RUN: ctr_en=1, conv_en_n=0; each cycle with rx_valid=1 increments word_cnt and reloads the timeout counter.
REQ-025 RUN: when the increment makes word_cnt equal NUM_WORDS -> DONE on the same edge; ctr_en=0 and conv_en_n=1 from that edge.
REQ-026 RUN: TIMEOUT consecutive cycles with rx_valid=0 -> ERR, and timeout_err is set to 1.
REQ-027 rx_valid has priority over timeout expiry when both fall in the same cycle.
REQ-028 DONE: done=1 for exactly one cycle -> IDLE.
REQ-029 ERR: ctr_en=0, conv_en_n=1 for one cycle -> IDLE; timeout_err stays 1 until the next accepted start or reset.
REQ-030 abort=1 in any non-IDLE state -> IDLE on the next edge:
  - ctr_clr=0, ctr_en=0, conv_en_n=1;
  - no done pulse;
  - word_cnt holds its value.
REQ-031 abort has priority over every other transition, including start and completion in the same cycle.
REQ-032 start SHALL be ignored while busy=1.
REQ-033 A start held high through DONE or ERR SHALL launch a new transfer from IDLE on the following edge.
REQ-034 rx_valid outside RUN SHALL be ignored.
REQ-035 word_cnt SHALL never exceed NUM_WORDS.
REQ-036 Phase counters SHALL be wide enough for the parameter values and SHALL never wrap.

Reset
REQ-037 rst_n=0 at a clock edge SHALL force, on that edge, from any state:
  - state IDLE;
  - ctr_clr=0, ctr_en=0, conv_en_n=1;
  - busy=0, done=0, timeout_err=0, word_cnt=0.
REQ-038 Reset asserted mid-transfer SHALL produce no done pulse, and the block SHALL accept start on the first edge after rst_n returns to 1.

Verification
REQ-039 Nominal (defaults): start pulsed high at edge 0 ->
  - ctr_clr=1 on edges 1-4;
  - ctr_en=1 from edge 10;
  - conv_en_n=0 from edge 15.
  Then 16 rx_valid pulses -> done=1 for one cycle, word_cnt=16, busy=0 the cycle after.
REQ-040 Timeout: RUN reached, 3 rx_valid pulses, then rx_valid=0 for 64 cycles -> ERR then IDLE, timeout_err=1, word_cnt=3, conv_en_n=1. A later start clears timeout_err.
REQ-041 Timeout tie: rx_valid=1 on the 64th idle cycle -> no error, word_cnt increments, RUN continues.
REQ-042 Abort: abort=1 in HOLD and again (separate transfer) in RUN with word_cnt=7 -> IDLE next edge, all enables safe, done never pulses, word_cnt=7 retained.
REQ-043 Start while busy, and start together with abort in CLEAR -> state sequence and timing unchanged by the start, abort wins; rx_valid in COUNT does not change word_cnt.
REQ-044 Reset mid-RUN: rst_n=0 for one edge at word_cnt=10 -> all outputs at reset values. A start one edge after release -> ctr_clr=1 on the following edge.
